bcp_core: RTL and testbench

- Boolean-constraint-propagation engine: the responder side of control's BCP handshake (bcp_en/reset_bcp in; bcp_busy/conflict/bcp_clause_idx out).
- On bcp_en it walks the occurrence-list slice [start_clause, end_clause) for the just-assigned variable and fetches each clause.
- Each clause is evaluated against current variable state; unit implications are pushed onto the imply stack and conflict is reported.
- Sits between control, the var start/end table, the occurrence and clause memories, var state, and imply_stack.

---
 rtl/bcp_core_pkg.sv | 26 ++
 rtl/bcp_core_if.sv | 48 ++++
 rtl/bcp_core_clause_eval.sv | 39 +++
 rtl/bcp_core.sv | 120 ++++++++++++
 tb/tb_bcp_core.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcp_core_pkg.sv
// rtl/bcp_core_pkg.sv - shared sizes, literal/clause types and FSM states for the BCP engine
package bcp_core_pkg;

    localparam int K                   = 3;
    localparam int MAX_VARS_BITS       = 8;
    localparam int MAX_CLAUSES_BITS    = 8;
    localparam int CLAUSE_TABLE_BITS   = 8;
    localparam int UNASSIGNED_CNT_BITS = $clog2(K + 1);

    typedef struct packed {
        logic                     valid;
        logic                     neg;
        logic [MAX_VARS_BITS-1:0] var_idx;
    } lit_t;

    typedef lit_t [K-1:0] clause_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        OCC,
        EVAL,
        DONE
    } bcp_state_t;

endpackage

// File: rtl/bcp_core_if.sv
// rtl/bcp_core_if.sv - control handshake, memory read ports, var-state lookup and imply push of the BCP engine
interface bcp_core_if;
    import bcp_core_pkg::*;

    logic                         reset_bcp;
    logic                         bcp_en;
    logic [CLAUSE_TABLE_BITS-1:0] start_clause;
    logic [CLAUSE_TABLE_BITS-1:0] end_clause;
    logic                         bcp_busy;
    logic                         conflict;
    logic [MAX_CLAUSES_BITS-1:0]  bcp_clause_idx;

    logic                         occ_rd_en;
    logic [CLAUSE_TABLE_BITS-1:0] occ_rd_addr;
    logic [MAX_CLAUSES_BITS-1:0]  occ_rd_data;
    logic                         cl_rd_en;
    logic [MAX_CLAUSES_BITS-1:0]  cl_rd_addr;
    clause_t                      cl_rd_data;

    logic [K-1:0][MAX_VARS_BITS-1:0] vs_var;
    logic [K-1:0]                    vs_val;
    logic [K-1:0]                    vs_unassigned;

    logic                         full_imply;
    logic                         push_imply;
    logic [MAX_VARS_BITS-1:0]     var_in_imply;
    logic                         val_in_imply;

    // slave is the BCP engine; master is the surrounding control/memory side
    modport slave (
        input  reset_bcp, bcp_en, start_clause, end_clause,
        output bcp_busy, conflict, bcp_clause_idx,
        output occ_rd_en, occ_rd_addr, input occ_rd_data,
        output cl_rd_en, cl_rd_addr, input cl_rd_data,
        output vs_var, input vs_val, vs_unassigned,
        input  full_imply, output push_imply, var_in_imply, val_in_imply
    );

    modport master (
        output reset_bcp, bcp_en, start_clause, end_clause,
        input  bcp_busy, conflict, bcp_clause_idx,
        input  occ_rd_en, occ_rd_addr, output occ_rd_data,
        input  cl_rd_en, cl_rd_addr, output cl_rd_data,
        input  vs_var, output vs_val, vs_unassigned,
        output full_imply, input push_imply, var_in_imply, val_in_imply
    );

endinterface

// File: rtl/bcp_core_clause_eval.sv
// rtl/bcp_core_clause_eval.sv - combinational clause evaluation: satisfied, conflicting, or unit with the forced literal
module bcp_core_clause_eval
    import bcp_core_pkg::*;
(
    input  clause_t                  lits,
    input  logic [K-1:0]             vs_val,
    input  logic [K-1:0]             vs_unassigned,
    output logic                     sat,
    output logic                     conflict,
    output logic                     unit,
    output logic [MAX_VARS_BITS-1:0] unit_var,
    output logic                     unit_val
);

    logic [UNASSIGNED_CNT_BITS-1:0] n_open;

    // Invalid literal slots are padding and take no part in the decision.
    always_comb begin
        sat      = 1'b0;
        n_open   = '0;
        unit_var = '0;
        unit_val = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (lits[i].valid) begin
                if (vs_unassigned[i]) begin
                    n_open   = n_open + UNASSIGNED_CNT_BITS'(1);
                    unit_var = lits[i].var_idx;
                    unit_val = ~lits[i].neg;
                end else if (vs_val[i] != lits[i].neg) begin
                    sat = 1'b1;
                end
            end
        end
    end

    assign conflict = !sat && (n_open == '0);
    assign unit     = !sat && (n_open == UNASSIGNED_CNT_BITS'(1));

endmodule

// File: rtl/bcp_core.sv
// rtl/bcp_core.sv - BCP engine: scans an occurrence-list slice, pushes unit implications, flags conflicts; BCP_EARLY_EXIT_EN stops at the first conflict
module bcp_core
    import bcp_core_pkg::*;
(
    input logic       clock,
    input logic       reset_n,
    bcp_core_if.slave bus
);

    bcp_state_t                   state;
    logic [CLAUSE_TABLE_BITS-1:0] ptr;
    logic [CLAUSE_TABLE_BITS-1:0] end_ptr;
    logic                         busy_r;
    logic                         conflict_r;
    logic [MAX_CLAUSES_BITS-1:0]  clause_idx_r;

    logic                     ev_sat;
    logic                     ev_conflict;
    logic                     ev_unit;
    logic [MAX_VARS_BITS-1:0] ev_unit_var;
    logic                     ev_unit_val;
    logic                     push_fire;

    bcp_core_clause_eval u_eval (
        .lits          (bus.cl_rd_data),
        .vs_val        (bus.vs_val),
        .vs_unassigned (bus.vs_unassigned),
        .sat           (ev_sat),
        .conflict      (ev_conflict),
        .unit          (ev_unit),
        .unit_var      (ev_unit_var),
        .unit_val      (ev_unit_val)
    );

    always_comb begin
        bus.vs_var = '0;
        for (int i = 0; i < K; i++) begin
            bus.vs_var[i] = bus.cl_rd_data[i].var_idx;
        end
    end

    // Reads issue from the state itself so each single-cycle memory returns
    // data exactly in the following state: CHECK -> OCC -> EVAL.
    assign bus.occ_rd_en   = (state == CHECK) && (ptr != end_ptr);
    assign bus.occ_rd_addr = ptr;
    assign bus.cl_rd_en    = (state == OCC);
    assign bus.cl_rd_addr  = bus.occ_rd_data;

    assign push_fire        = (state == EVAL) && ev_unit && !bus.full_imply && !bus.reset_bcp;
    assign bus.push_imply   = push_fire;
    assign bus.var_in_imply = ev_unit_var;
    assign bus.val_in_imply = ev_unit_val;

    assign bus.bcp_busy       = busy_r;
    assign bus.conflict       = conflict_r;
    assign bus.bcp_clause_idx = clause_idx_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            end_ptr      <= '0;
            busy_r       <= 1'b0;
            conflict_r   <= 1'b0;
            clause_idx_r <= '0;
        end else if (bus.reset_bcp) begin
            state        <= IDLE;
            ptr          <= '0;
            end_ptr      <= '0;
            busy_r       <= 1'b0;
            conflict_r   <= 1'b0;
            clause_idx_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bcp_en) begin
                        ptr        <= bus.start_clause;
                        end_ptr    <= bus.end_clause;
                        conflict_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    state <= (ptr == end_ptr) ? DONE : OCC;
                end
                OCC: begin
                    // Once a conflict is flagged the index stays on the first offender.
                    if (!conflict_r) begin
                        clause_idx_r <= bus.occ_rd_data;
                    end
                    state <= EVAL;
                end
                EVAL: begin
                    if (ev_conflict) begin
                        conflict_r <= 1'b1;
`ifdef BCP_EARLY_EXIT_EN
                        state      <= DONE;
`else
                        ptr        <= ptr + CLAUSE_TABLE_BITS'(1);
                        state      <= CHECK;
`endif
                    end else if (ev_sat || !ev_unit || !bus.full_imply) begin
                        ptr   <= ptr + CLAUSE_TABLE_BITS'(1);
                        state <= CHECK;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcp_core.sv
// tb/tb_bcp_core.sv - self-checking bench for bcp_core: clause table, directed corner sequences, randomized scans vs reference model
module tb_bcp_core;
    import bcp_core_pkg::*;

`ifdef BCP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bcp_core_if bif ();

    bcp_core u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    logic [7:0] occ_mem [256];
    clause_t    cl_mem  [256];
    logic       vval    [256];
    logic       vuna    [256];

    int tests = 0;
    int fails = 0;
    int occ_reads = 0;
    int cl_reads = 0;
    int push_while_full = 0;
    int push_var_q [$];
    int push_val_q [$];
    int base_occ, base_cl, base_push;

    // single-cycle registered memories that hold their output when not read
    always @(posedge clock) begin
        if (bif.occ_rd_en) begin
            bif.occ_rd_data <= occ_mem[bif.occ_rd_addr];
            occ_reads       <= occ_reads + 1;
        end
        if (bif.cl_rd_en) begin
            bif.cl_rd_data <= cl_mem[bif.cl_rd_addr];
            cl_reads       <= cl_reads + 1;
        end
        if (bif.push_imply) begin
            push_var_q.push_back(int'(bif.var_in_imply));
            push_val_q.push_back(int'(bif.val_in_imply));
            if (bif.full_imply) push_while_full <= push_while_full + 1;
        end
    end

    always_comb begin
        bif.vs_val        = '0;
        bif.vs_unassigned = '0;
        for (int i = 0; i < K; i++) begin
            bif.vs_val[i]        = vval[bif.vs_var[i]];
            bif.vs_unassigned[i] = vuna[bif.vs_var[i]];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic lit_t mkl(input logic v, input logic n, input int x);
        lit_t r;
        r.valid   = v;
        r.neg     = n;
        r.var_idx = 8'(x);
        return r;
    endfunction

    function automatic clause_t mk3(input lit_t a, input lit_t b, input lit_t c);
        clause_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        return r;
    endfunction

    task automatic clear_vars();
        for (int v = 0; v < 256; v++) begin
            vval[v] = 1'b0;
            vuna[v] = 1'b1;
        end
    endtask

    task automatic set_var(input int v, input logic b);
        vval[v] = b;
        vuna[v] = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] s, input logic [7:0] e);
        @(negedge clock);
        bif.start_clause = s;
        bif.end_clause   = e;
        bif.bcp_en       = 1'b1;
        base_occ  = occ_reads;
        base_cl   = cl_reads;
        base_push = push_var_q.size();
        @(negedge clock);
        bif.bcp_en = 1'b0;
    endtask

    task automatic finish_scan(inout int cyc);
        while (bif.bcp_busy && cyc < 500) begin
            cyc++;
            @(negedge clock);
        end
        check("scan timeout", int'(bif.bcp_busy), 0);
    endtask

    // reference model: walks the slice clause by clause using literal counts
    int m_busy, m_n, m_idx;
    logic m_conf;
    int m_pv [$];
    int m_pb [$];

    task automatic model_scan(input logic [7:0] s, input logic [7:0] e);
        logic [7:0] p;
        p = s;
        m_conf = 1'b0;
        m_idx = 0;
        m_n = 0;
        m_pv.delete();
        m_pb.delete();
        while (p != e) begin
            clause_t c;
            int n_true;
            int n_open;
            int uv;
            int ub;
            c = cl_mem[occ_mem[p]];
            n_true = 0;
            n_open = 0;
            uv = 0;
            ub = 0;
            m_n++;
            for (int i = 0; i < K; i++) begin
                if (c[i].valid) begin
                    if (vuna[c[i].var_idx]) begin
                        n_open++;
                        uv = int'(c[i].var_idx);
                        ub = c[i].neg ? 0 : 1;
                    end else if (vval[c[i].var_idx] != c[i].neg) begin
                        n_true++;
                    end
                end
            end
            if (n_true == 0 && n_open == 0) begin
                if (!m_conf) m_idx = int'(occ_mem[p]);
                m_conf = 1'b1;
                if (EARLY_EXIT) break;
            end else if (n_true == 0 && n_open == 1) begin
                m_pv.push_back(uv);
                m_pb.push_back(ub);
            end
            p = p + 8'd1;
        end
        m_busy = 3 * m_n + ((EARLY_EXIT && m_conf) ? 1 : 2);
    endtask

    task automatic compare_model(input string tag, input int cyc);
        check({tag, " busy"}, cyc, m_busy);
        check({tag, " conflict"}, int'(bif.conflict), int'(m_conf));
        if (m_conf) check({tag, " clause_idx"}, int'(bif.bcp_clause_idx), m_idx);
        check({tag, " occ reads"}, occ_reads - base_occ, m_n);
        check({tag, " cl reads"}, cl_reads - base_cl, m_n);
        check({tag, " pushes"}, push_var_q.size() - base_push, m_pv.size());
        for (int i = 0; i < m_pv.size() && base_push + i < push_var_q.size(); i++) begin
            check({tag, " push var"}, push_var_q[base_push + i], m_pv[i]);
            check({tag, " push val"}, push_val_q[base_push + i], m_pb[i]);
        end
    endtask

    typedef struct {
        string   name;
        clause_t lits;
        logic [K-1:0] val;
        logic [K-1:0] una;
        logic    exp_conf;
        logic    exp_push;
        int      exp_var;
        int      exp_val;
    } vec_t;

    vec_t tv [$];

    initial begin
        int cyc;
        lit_t p1, p2, p3, n1, n3, i1, i2, i3, z;
        p1 = mkl(1, 0, 1); p2 = mkl(1, 0, 2); p3 = mkl(1, 0, 3);
        n1 = mkl(1, 1, 1); n3 = mkl(1, 1, 3);
        i1 = mkl(0, 0, 1); i2 = mkl(0, 0, 2); i3 = mkl(0, 0, 3);
        z  = mkl(0, 0, 0);

        tv.push_back('{"sat_first",    mk3(p1, p2, p3), 3'b001, 3'b000, 1'b0, 1'b0, 0, 0});
        tv.push_back('{"all_false",    mk3(p1, p2, p3), 3'b000, 3'b000, 1'b1, 1'b0, 0, 0});
        tv.push_back('{"unit_pos",     mk3(p1, p2, p3), 3'b000, 3'b100, 1'b0, 1'b1, 3, 1});
        tv.push_back('{"unit_neg",     mk3(n1, p2, n3), 3'b001, 3'b100, 1'b0, 1'b1, 3, 0});
        tv.push_back('{"two_open",     mk3(p1, p2, p3), 3'b000, 3'b011, 1'b0, 1'b0, 0, 0});
        tv.push_back('{"inval_open",   mk3(i1, p2, p3), 3'b000, 3'b001, 1'b1, 1'b0, 0, 0});
        tv.push_back('{"inval_true",   mk3(i1, p2, p3), 3'b001, 3'b100, 1'b0, 1'b1, 3, 1});
        tv.push_back('{"all_invalid",  mk3(i1, i2, i3), 3'b000, 3'b111, 1'b1, 1'b0, 0, 0});
        tv.push_back('{"neg_true",     mk3(n1, p2, p3), 3'b000, 3'b110, 1'b0, 1'b0, 0, 0});
        tv.push_back('{"three_open",   mk3(p1, p2, p3), 3'b000, 3'b111, 1'b0, 1'b0, 0, 0});

        for (int i = 0; i < 256; i++) begin
            occ_mem[i] = 8'd0;
            cl_mem[i]  = '0;
        end
        clear_vars();
        bif.reset_bcp = 1'b0;
        bif.bcp_en = 1'b0;
        bif.start_clause = '0;
        bif.end_clause = '0;
        bif.full_imply = 1'b0;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset busy", int'(bif.bcp_busy), 0);
        check("reset conflict", int'(bif.conflict), 0);
        check("reset clause_idx", int'(bif.bcp_clause_idx), 0);
        check("reset occ_rd_en", int'(bif.occ_rd_en), 0);
        check("reset cl_rd_en", int'(bif.cl_rd_en), 0);
        check("reset push", int'(bif.push_imply), 0);

        // single-clause table
        occ_mem[40] = 8'd10;
        foreach (tv[n]) begin
            clear_vars();
            cl_mem[10] = tv[n].lits;
            for (int i = 0; i < K; i++) begin
                vval[tv[n].lits[i].var_idx] = tv[n].val[i];
                vuna[tv[n].lits[i].var_idx] = tv[n].una[i];
            end
            pulse_start(8'd40, 8'd41);
            cyc = 0;
            finish_scan(cyc);
            check({tv[n].name, " busy"}, cyc, 5);
            check({tv[n].name, " conflict"}, int'(bif.conflict), int'(tv[n].exp_conf));
            if (tv[n].exp_conf) check({tv[n].name, " idx"}, int'(bif.bcp_clause_idx), 10);
            check({tv[n].name, " pushes"}, push_var_q.size() - base_push, tv[n].exp_push ? 1 : 0);
            if (tv[n].exp_push && push_var_q.size() > base_push) begin
                check({tv[n].name, " push var"}, push_var_q[base_push], tv[n].exp_var);
                check({tv[n].name, " push val"}, push_val_q[base_push], tv[n].exp_val);
            end
        end

        // three-clause range with a second bcp_en during the scan
        clear_vars();
        set_var(1, 1'b1);
        set_var(3, 1'b1);
        cl_mem[1] = mk3(p1, p2, z);
        cl_mem[2] = mk3(n3, mkl(1, 0, 4), mkl(1, 0, 5));
        cl_mem[3] = mk3(mkl(1, 0, 6), z, z);
        cl_mem[4] = mk3(mkl(1, 1, 2), mkl(1, 0, 7), z);
        cl_mem[5] = mk3(mkl(1, 0, 9), mkl(1, 1, 10), z);
        occ_mem[0] = 8'd1; occ_mem[1] = 8'd2; occ_mem[2] = 8'd3;
        pulse_start(8'd0, 8'd3);
        bif.start_clause = 8'd200;
        bif.end_clause = 8'd200;
        bif.bcp_en = 1'b1;
        cyc = 1;
        @(negedge clock);
        bif.bcp_en = 1'b0;
        finish_scan(cyc);
        check("seq1 busy", cyc, 11);
        check("seq1 conflict", int'(bif.conflict), 0);
        check("seq1 pushes", push_var_q.size() - base_push, 1);
        check("seq1 push var", push_var_q[push_var_q.size() - 1], 6);
        check("seq1 push val", push_val_q[push_val_q.size() - 1], 1);
        model_scan(8'd0, 8'd3);
        compare_model("seq1 model", cyc);

        // conflicting clause, held until the next accepted start
        set_var(2, 1'b1);
        set_var(7, 1'b0);
        occ_mem[20] = 8'd4;
        pulse_start(8'd20, 8'd21);
        cyc = 0;
        finish_scan(cyc);
        check("conf flag", int'(bif.conflict), 1);
        check("conf idx", int'(bif.bcp_clause_idx), 4);
        check("conf pushes", push_var_q.size() - base_push, 0);
        repeat (5) @(negedge clock);
        check("conf held", int'(bif.conflict), 1);
        check("conf idx held", int'(bif.bcp_clause_idx), 4);

        // empty range
        pulse_start(8'd5, 8'd5);
        check("empty clears conflict", int'(bif.conflict), 0);
        cyc = 0;
        finish_scan(cyc);
        check("empty busy", cyc, 2);
        check("empty occ reads", occ_reads - base_occ, 0);
        check("empty cl reads", cl_reads - base_cl, 0);

        // unit clause stalled by a full imply stack for 4 EVAL cycles
        set_var(10, 1'b1);
        occ_mem[30] = 8'd5;
        bif.full_imply = 1'b1;
        pulse_start(8'd30, 8'd31);
        cyc = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k >= 3) check("stall no push", int'(bif.push_imply), 0);
            cyc++;
            @(negedge clock);
        end
        bif.full_imply = 1'b0;
        finish_scan(cyc);
        check("stall busy", cyc, 9);
        check("stall pushes", push_var_q.size() - base_push, 1);
        check("stall push var", push_var_q[push_var_q.size() - 1], 9);
        check("stall push val", push_val_q[push_val_q.size() - 1], 1);
        check("push while full", push_while_full, 0);

        // reset_bcp in OCC
        pulse_start(8'd30, 8'd31);
        @(negedge clock);
        bif.reset_bcp = 1'b1;
        @(negedge clock);
        check("soft reset busy", int'(bif.bcp_busy), 0);
        check("soft reset push", int'(bif.push_imply), 0);
        bif.reset_bcp = 1'b0;
        repeat (4) @(negedge clock);
        check("soft reset no push", push_var_q.size() - base_push, 0);

        // reset_bcp beats bcp_en
        bif.reset_bcp = 1'b1;
        bif.bcp_en = 1'b1;
        @(negedge clock);
        bif.reset_bcp = 1'b0;
        bif.bcp_en = 1'b0;
        check("reset wins busy", int'(bif.bcp_busy), 0);

        // async reset in EVAL
        pulse_start(8'd30, 8'd31);
        @(negedge clock);
        @(negedge clock);
        check("eval push before reset", int'(bif.push_imply), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async busy", int'(bif.bcp_busy), 0);
        check("async push", int'(bif.push_imply), 0);
        check("async idx", int'(bif.bcp_clause_idx), 0);
        check("async cl_rd_en", int'(bif.cl_rd_en), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("async no push", push_var_q.size() - base_push, 0);

        // five clauses, conflict at the second one
        occ_mem[50] = 8'd1; occ_mem[51] = 8'd4; occ_mem[52] = 8'd3;
        occ_mem[53] = 8'd5; occ_mem[54] = 8'd2;
        pulse_start(8'd50, 8'd55);
        cyc = 0;
        finish_scan(cyc);
        check("exit busy", cyc, EARLY_EXIT ? 7 : 17);
        check("exit cl reads", cl_reads - base_cl, EARLY_EXIT ? 2 : 5);
        check("exit pushes", push_var_q.size() - base_push, EARLY_EXIT ? 0 : 2);
        check("exit idx", int'(bif.bcp_clause_idx), 4);
        model_scan(8'd50, 8'd55);
        compare_model("exit model", cyc);

        // randomized scans, including ranges that wrap through 255
        for (int it = 0; it < 40; it++) begin
            logic [7:0] s;
            logic [7:0] e;
            int len;
            clear_vars();
            for (int v = 0; v < 16; v++) begin
                vuna[v] = ($urandom_range(0, 2) == 0);
                vval[v] = 1'($urandom_range(0, 1));
            end
            for (int c = 0; c < 32; c++) begin
                cl_mem[100 + c] = mk3(mkl($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15))),
                                      mkl($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15))),
                                      mkl($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15))));
            end
            s = (it == 0) ? 8'd253 : 8'($urandom_range(0, 255));
            len = (it == 0) ? 5 : int'($urandom_range(0, 7));
            e = s + 8'(len);
            for (int k = 0; k < len; k++) begin
                occ_mem[8'(s + 8'(k))] = 8'(100 + $urandom_range(0, 31));
            end
            pulse_start(s, e);
            cyc = 0;
            finish_scan(cyc);
            model_scan(s, e);
            compare_model("rand", cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
